// File: rtl/sw_conditioner.sv
// Switch conditioner: 2-flop sync, per-channel debounce FSM, rise pulse and sticky request.
// Optional shared glitch counter enabled by defining SW_COND_GLITCH_CNT_EN.
module sw_conditioner #(
  parameter int N               = 5,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic         CLK100MHZ,
  input  logic         reset,
  input  logic [N-1:0] sw_i,
  input  logic [N-1:0] req_clr_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] req_o,
  output logic [7:0]   glitch_cnt_o
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  logic [N-1:0]  sw_meta_r, sw_sync_r;
  logic [N-1:0]  clr_meta_r, clr_sync_r, clr_dly_r;
  state_t        state_r [N];
  state_t        state_s [N];
  logic [CW-1:0] cnt_r [N];
  logic [CW-1:0] cnt_s [N];
  logic [N-1:0]  level_s, rise_s, req_s, clr_pulse_s;
  logic [N-1:0]  level_r, rise_r, req_r;

  // Synchronise raw switches and acknowledges into the system clock domain.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sw_meta_r  <= '0;
      sw_sync_r  <= '0;
      clr_meta_r <= '0;
      clr_sync_r <= '0;
      clr_dly_r  <= '0;
    end else begin
      sw_meta_r  <= sw_i;
      sw_sync_r  <= sw_meta_r;
      clr_meta_r <= req_clr_i;
      clr_sync_r <= clr_meta_r;
      clr_dly_r  <= clr_sync_r;
    end
  end

  // Debounce next-state: a change is accepted only after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_s[i] = state_r[i];
      cnt_s[i]   = cnt_r[i];
      rise_s[i]  = 1'b0;
      case (state_r[i])
        ST_LOW: begin
          if (sw_sync_r[i]) begin
            state_s[i] = ST_WAIT_HIGH;
            cnt_s[i]   = CNT_ONE;
          end else begin
            state_s[i] = ST_LOW;
          end
        end
        ST_WAIT_HIGH: begin
          if (!sw_sync_r[i]) begin
            state_s[i] = ST_LOW;
          end else if (cnt_r[i] == CNT_LAST) begin
            state_s[i] = ST_HIGH;
            rise_s[i]  = 1'b1;
          end else begin
            cnt_s[i] = cnt_r[i] + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!sw_sync_r[i]) begin
            state_s[i] = ST_WAIT_LOW;
            cnt_s[i]   = CNT_ONE;
          end else begin
            state_s[i] = ST_HIGH;
          end
        end
        ST_WAIT_LOW: begin
          if (sw_sync_r[i]) begin
            state_s[i] = ST_HIGH;
          end else if (cnt_r[i] == CNT_LAST) begin
            state_s[i] = ST_LOW;
          end else begin
            cnt_s[i] = cnt_r[i] + CNT_ONE;
          end
        end
        default: begin
          state_s[i] = ST_LOW;
          cnt_s[i]   = '0;
        end
      endcase
      level_s[i] = (state_s[i] == ST_HIGH) || (state_s[i] == ST_WAIT_LOW);
    end
  end

  // Set has priority over a simultaneous acknowledge edge.
  assign clr_pulse_s = clr_sync_r & ~clr_dly_r;
  assign req_s       = rise_s | (req_r & ~clr_pulse_s);

  // Channel state and registered outputs.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        state_r[i] <= ST_LOW;
        cnt_r[i]   <= '0;
      end
      level_r <= '0;
      rise_r  <= '0;
      req_r   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_r[i] <= state_s[i];
        cnt_r[i]   <= cnt_s[i];
      end
      level_r <= level_s;
      rise_r  <= rise_s;
      req_r   <= req_s;
    end
  end

  assign level_o = level_r;
  assign rise_o  = rise_r;
  assign req_o   = req_r;

`ifdef SW_COND_GLITCH_CNT_EN
  localparam int GW = 9 + $clog2(N + 1);

  logic [N-1:0]  abort_s;
  logic [GW-1:0] glitch_sum_s;
  logic [7:0]    glitch_r;

  // Sum all aborts this cycle onto the shared counter.
  always_comb begin
    glitch_sum_s = GW'(glitch_r);
    for (int i = 0; i < N; i++) begin
      abort_s[i] = ((state_r[i] == ST_WAIT_HIGH) && !sw_sync_r[i]) ||
                   ((state_r[i] == ST_WAIT_LOW)  &&  sw_sync_r[i]);
      glitch_sum_s = glitch_sum_s + GW'(abort_s[i]);
    end
  end

  // Saturating glitch counter.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      glitch_r <= 8'd0;
    end else if (glitch_sum_s > GW'(255)) begin
      glitch_r <= 8'd255;
    end else begin
      glitch_r <= glitch_sum_s[7:0];
    end
  end

  assign glitch_cnt_o = glitch_r;
`else
  assign glitch_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_sw_conditioner.sv
// Self-checking bench for sw_conditioner: vector table, directed corner sequences, random run.
module tb_sw_conditioner;
  localparam int N  = 5;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] sw, clr;
  logic [N-1:0] level_o, rise_o, req_o;
  logic [7:0]   glitch_cnt_o;

  sw_conditioner #(.N(N), .DEBOUNCE_CYCLES(DC)) dut (
    .CLK100MHZ   (clk),
    .reset       (reset),
    .sw_i        (sw),
    .req_clr_i   (clr),
    .level_o     (level_o),
    .rise_o      (rise_o),
    .req_o       (req_o),
    .glitch_cnt_o(glitch_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: run-length debounce over the synchronised sample stream.
  bit [N-1:0] m_sy1, m_sy2, m_cs1, m_cs2, m_cd;
  bit [N-1:0] m_level, m_rise, m_req;
  int         m_run [N];
  int         m_glitch;

  typedef struct {
    logic [N-1:0] sw;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] req;
  } vec_t;
  vec_t tv [8];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_sy1 = '0; m_sy2 = '0; m_cs1 = '0; m_cs2 = '0; m_cd = '0;
    m_level = '0; m_rise = '0; m_req = '0; m_glitch = 0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    bit [N-1:0] s;
    bit [N-1:0] cp;
    s  = m_sy2;
    cp = m_cs2 & ~m_cd;
    m_rise = '0;
    for (int i = 0; i < N; i++) begin
      if (s[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_level[i] = s[i];
          m_run[i]   = 0;
          if (s[i]) m_rise[i] = 1'b1;
        end
      end else begin
        if (m_run[i] > 0 && m_glitch < 255) m_glitch++;
        m_run[i] = 0;
      end
    end
    m_req = m_rise | (m_req & ~cp);
    m_cd  = m_cs2; m_cs2 = m_cs1; m_cs1 = clr;
    m_sy2 = m_sy1; m_sy1 = sw;
  endtask

  function automatic int exp_glitch(input int g);
`ifdef SW_COND_GLITCH_CNT_EN
    return g;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("level", level_o, m_level);
    check("rise", rise_o, m_rise);
    check("req", req_o, m_req);
    check("glitch", glitch_cnt_o, exp_glitch(m_glitch));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, level_o, 0);
    check({tag, "_rise"}, rise_o, 0);
    check({tag, "_req"}, req_o, 0);
    check({tag, "_glitch"}, glitch_cnt_o, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_zero("reset");
    #1;
    reset = 1'b0;
  endtask

  initial begin
    tv[0] = '{5'b00001, 5'b00000, 5'b00000, 5'b00000};
    tv[1] = '{5'b00001, 5'b00000, 5'b00000, 5'b00000};
    tv[2] = '{5'b00001, 5'b00000, 5'b00000, 5'b00000};
    tv[3] = '{5'b00001, 5'b00000, 5'b00000, 5'b00000};
    tv[4] = '{5'b00001, 5'b00000, 5'b00000, 5'b00000};
    tv[5] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001};
    tv[6] = '{5'b00001, 5'b00001, 5'b00000, 5'b00001};
    tv[7] = '{5'b00001, 5'b00001, 5'b00000, 5'b00001};

    sw = '0; clr = '0; reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("por");
    reset = 1'b0;

    // Clean press on channel 0 from the vector table.
    for (int k = 0; k < 8; k++) begin
      sw = tv[k].sw;
      step();
      check("t1_level", level_o, tv[k].level);
      check("t1_rise", rise_o, tv[k].rise);
      check("t1_req", req_o, tv[k].req);
    end

    // Release channel 0: level falls after 6 edges, request stays.
    sw[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t3_level", level_o[0], (k >= 6) ? 0 : 1);
      check("t3_rise", rise_o[0], 0);
      check("t3_req", req_o[0], 1);
    end

    // Bounce rejection on channel 1.
    do_reset();
    sw = '0;
    for (int k = 0; k < 12; k++) begin
      sw[1] = (k < 3 || (k >= 4 && k < 7)) ? 1'b1 : 1'b0;
      step();
      check("t2_level", level_o[1], 0);
      check("t2_rise", rise_o[1], 0);
    end
    check("t2_glitch_total", glitch_cnt_o, exp_glitch(2));

    // Acknowledge on channel 2 with a held-high clear.
    do_reset();
    sw = 5'b00100;
    repeat (8) step();
    check("t4_req_set", req_o[2], 1);
    clr[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("t4_req_clr", req_o[2], (k >= 3) ? 0 : 1);
    end
    clr[2] = 1'b0;
    sw[2]  = 1'b0;
    repeat (8) step();
    check("t4_req_idle", req_o[2], 0);
    sw[2] = 1'b1;
    repeat (8) step();
    check("t4_req_reset", req_o[2], 1);

    // Set/clear collision on channel 3: clear edge lands on the rise cycle.
    do_reset();
    sw = 5'b01000;
    repeat (3) step();
    clr[3] = 1'b1;
    for (int k = 4; k <= 12; k++) begin
      step();
      if (k == 6) check("t5_rise", rise_o[3], 1);
      if (k >= 6) check("t5_req", req_o[3], 1);
    end
    clr = '0;

    // Reset mid-debounce on channel 4.
    do_reset();
    sw = 5'b10000;
    repeat (2) step();
    reset = 1'b1;
    #1;
    model_reset();
    check_zero("t6_async");
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t6_rise", rise_o[4], (k == 6) ? 1 : 0);
    end

    // Random stimulus against the reference model.
    do_reset();
    sw = '0; clr = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) sw[i] = ~sw[i];
        clr[i] = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sw_conditioner.md
Name: sw_conditioner

Overview:
Input conditioning stage that sits directly upstream of the traffic-light controller (semaforo) and consumes the raw board switches sw[4:0].
- Synchronises each switch into the CLK100MHZ domain, debounces it, and presents a clean level.
- Presents a one-cycle rising-edge pulse per channel.
- Presents a sticky request flag per channel. The request flag holds until the slow-clock controller acknowledges it, so no press is lost across the prescaled clock boundary.

Parameters:
N, 5, number of switch channels conditioned.
DEBOUNCE_CYCLES, 1000000, consecutive stable CLK100MHZ cycles required before a level change is accepted (10 ms); legal range ≥ 2.

Ports:
CLK100MHZ  input  1  system clock, 100 MHz, all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
sw_i  input  N  raw, asynchronous switch inputs.
req_clr_i  input  N  per-channel request acknowledge from the prescaled-clock domain; level, asynchronous to CLK100MHZ.
level_o  output  N  debounced switch level.
rise_o  output  N  one-cycle pulse on each accepted 0→1 transition.
req_o  output  N  sticky request flag, set by rise, cleared by acknowledge.
glitch_cnt_o  output  8  saturating count of rejected bounces (see Optional Feature).

Behaviour:
Reset:
- All outputs go to 0 immediately on reset high: level_o, rise_o, req_o, glitch_cnt_o.
- Both synchroniser stages go to 0 on every channel (sw and req_clr).
- Every channel FSM goes to ST_LOW, and every debounce counter goes to 0.
- Reset asserted mid-debounce discards the partial count; no rise_o is emitted.

Synchroniser:
- Two flops per sw_i bit produce s[i]. The raw pin is never used elsewhere.

Per-channel FSM, with states ST_LOW, ST_WAIT_HIGH, ST_HIGH, ST_WAIT_LOW:
- ST_LOW: when s=1, go to ST_WAIT_HIGH and load cnt=1.
- ST_WAIT_HIGH:
  - s=0: return to ST_LOW and count one glitch.
  - s=1 and cnt=DEBOUNCE_CYCLES-1: go to ST_HIGH.
  - Otherwise increment cnt.
- ST_HIGH: when s=0, go to ST_WAIT_LOW and load cnt=1.
- ST_WAIT_LOW: mirror of ST_WAIT_HIGH, returning to ST_HIGH on glitch and going to ST_LOW on completion.
- level_o is 1 exactly in ST_HIGH and ST_WAIT_LOW.
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps because it is bounded by the terminal compare.

Latency:
- level_o changes DEBOUNCE_CYCLES cycles after s[i] first differs from it.
- That is 2+DEBOUNCE_CYCLES rising edges after a clean pin change.

rise_o:
- High for exactly the one cycle in which level_o first reads 1 after ST_WAIT_HIGH→ST_HIGH.
- No pulse is generated on falling transitions.

req_o:
- Set in the same cycle rise_o is high.
- req_clr_i passes through a two-flop synchroniser, then a rising-edge detector.
- req_o clears on the 3rd rising edge after req_clr_i goes high.
- A held-high req_clr_i clears only once.
- If set and clear occur in the same cycle, set wins and req_o stays 1.
- A new rise while req_o=1 leaves it at 1; no counting.

Channels:
- Channels are fully independent. Simultaneous events on multiple channels are handled in parallel with no priority.

Optional Feature:
Macro: SW_COND_GLITCH_CNT_EN.
- Defined:
  - glitch_cnt_o is an 8-bit counter shared by all channels.
  - It adds the number of channels that take a WAIT→stable-state abort in the current cycle.
  - It saturates at 255 and is reset to 0 by reset.
  - Counter logic must handle up to N simultaneous aborts in one cycle.
- Not defined: glitch_cnt_o is tied to 8'd0 and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
All tests use DEBOUNCE_CYCLES=4 and N=5.
1. Clean press: reset, then sw_i[0] 0→1 held → level_o[0]=1, rise_o[0]=1 for one cycle, and req_o[0]=1, all exactly 6 edges after the pin change; other channels stay 0.
2. Bounce rejection: sw_i[1] high for 3 cycles, low for 1, high for 3, then low → level_o[1] stays 0, rise_o never pulses, and glitch_cnt_o=2 (macro on) or 0 (macro off).
3. Release: after test 1, sw_i[0] 1→0 → level_o[0]=0 6 edges later; no rise_o and req_o[0] stays 1.
4. Acknowledge: req_o[2]=1, then req_clr_i[2] held high for 10 cycles → req_o[2]=0 on the 3rd edge and stays 0; a new debounced press sets it again.
5. Set/clear collision: align the req_clr_i[3] edge detection with the rise_o[3] cycle → req_o[3] remains 1.
6. Reset mid-debounce: sw_i[4]=1 for 2 cycles, then assert reset → all outputs 0 asynchronously. After release with sw_i[4] still 1, rise_o[4] pulses exactly 6 edges after the reset deassertion.
